// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared types and defaults for the register-file write arbiter
package regfile_write_arbiter_pkg;

    typedef enum logic {ARB_INIT, ARB_RUN} arb_state_t;

    parameter int DBG_STARVE_LIMIT_DEFAULT = 8;

endpackage

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port between init, writeback and debug
// Init zeroes x1..NUM_REGS-1 after reset; afterwards writeback always wins and debug takes idle cycles.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int                NUM_REGS     = 32,
    parameter int                ADDR_W       = 5,
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE   = '0,
    parameter int                STARVE_LIMIT = DBG_STARVE_LIMIT_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REG_W_En_W,
    input  logic [ADDR_W-1:0] RD_W,
    input  logic [DATA_W-1:0] Result_W,
    input  logic              DBG_Req,
    input  logic [ADDR_W-1:0] DBG_Addr,
    input  logic [DATA_W-1:0] DBG_Data,
    output logic              DBG_Ack,
    output logic              REG_W_En,
    output logic [ADDR_W-1:0] REG_W_Addr,
    output logic [DATA_W-1:0] REG_W_Data,
    output logic              Stall_Out,
    output logic              Init_Done
);

    localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        r_state;
    logic [ADDR_W-1:0] r_init_idx;
    logic [CNT_W-1:0]  r_starve_cnt;

    logic w_run;
    logic w_wb_live;
    logic w_grant;

    assign w_run     = (r_state == ARB_RUN);
    // A writeback to x0 is not a real write, so debug may use that cycle.
    assign w_wb_live = REG_W_En_W && (RD_W != '0);
    assign w_grant   = w_run && DBG_Req && !w_wb_live;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ARB_INIT;
            r_init_idx   <= ADDR_W'(1);
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ARB_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == LAST_IDX) begin
                        r_state <= ARB_RUN;
                    end
                end
                ARB_RUN: begin
                    if (DBG_Req && !w_grant) begin
                        if (r_starve_cnt != STARVE_MAX) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                default: r_state <= ARB_INIT;
            endcase
        end
    end

    // Reset gates the port combinationally so an asserted RST blocks the write in the same cycle.
    always_comb begin
        REG_W_En   = 1'b0;
        REG_W_Addr = '0;
        REG_W_Data = '0;
        DBG_Ack    = 1'b0;
        if (!RST) begin
            if (!w_run) begin
                REG_W_En   = 1'b1;
                REG_W_Addr = r_init_idx;
                REG_W_Data = INIT_VALUE;
            end else if (w_wb_live) begin
                REG_W_En   = 1'b1;
                REG_W_Addr = RD_W;
                REG_W_Data = Result_W;
            end else if (w_grant) begin
                DBG_Ack = 1'b1;
                if (DBG_Addr != '0) begin
                    REG_W_En   = 1'b1;
                    REG_W_Addr = DBG_Addr;
                    REG_W_Data = DBG_Data;
                end
            end
        end
    end

    assign Stall_Out = RST || !w_run || (r_starve_cnt == STARVE_MAX);
    assign Init_Done = !RST && w_run;

endmodule
